// File: rtl/sal_arbiter_rr_64to1.sv
// sal_arbiter_rr_64to1
//   Round-robin arbiter merging REQ_CNT producers onto one downstream
//   valid/grant channel. A single pointer holds the highest-priority index;
//   selection is purely combinational and the pointer advances past the
//   winner on every accepted transfer.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, forces outputs to zero
//   req_arr_i  : per-requester request bits
//   data_arr_i : per-requester data words
//   gnt_arr_o  : one-hot grant back to the winning requester on transfer
//   req_o      : downstream valid, high when any requester is requesting
//   data_o     : data word of the current winner (zero when idle)
//   gnt_i      : downstream accept
module sal_arbiter_rr_64to1 #(
  parameter int REQ_CNT    = 64,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQ_CNT-1:0]    req_arr_i,
  input  logic [DATA_WIDTH-1:0] data_arr_i [0:REQ_CNT-1],
  output logic [REQ_CNT-1:0]    gnt_arr_o,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  gnt_i
);

  localparam int PTR_W = $clog2(REQ_CNT);

  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     ptr_d;
  logic [REQ_CNT-1:0]   mask_hi;
  logic [2*REQ_CNT-1:0] req_dbl;
  logic [PTR_W-1:0]     winner;
  logic                 found;
  logic                 xfer;

  // Lower half holds only requests at or above the pointer; upper half holds
  // all requests. The first set bit of the doubled vector is the circular
  // winner, and its index modulo REQ_CNT is the requester number.
  always_comb begin
    mask_hi = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      mask_hi[i] = (i >= int'(ptr_q));
    end
    req_dbl = {req_arr_i, req_arr_i & mask_hi};
    winner  = '0;
    found   = 1'b0;
    for (int i = 0; i < 2*REQ_CNT; i++) begin
      if (!found && req_dbl[i]) begin
        found  = 1'b1;
        winner = PTR_W'(i);
      end
    end
  end

  always_comb begin
    req_o     = 1'b0;
    data_o    = '0;
    gnt_arr_o = '0;
    xfer      = 1'b0;
    ptr_d     = ptr_q;
    if (!rst && (|req_arr_i)) begin
      req_o  = 1'b1;
      data_o = data_arr_i[winner];
      if (gnt_i) begin
        xfer              = 1'b1;
        gnt_arr_o[winner] = 1'b1;
        // Power-of-two REQ_CNT makes the natural PTR_W-bit wrap the modulo.
        ptr_d             = winner + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_sal_arbiter_rr_64to1.sv
module tb_sal_arbiter_rr_64to1;

  localparam int N  = 64;
  localparam int DW = 12;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_arr_i;
  logic [DW-1:0] data_arr_i [0:N-1];
  logic [N-1:0]  gnt_arr_o;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          gnt_i;

  sal_arbiter_rr_64to1 #(.REQ_CNT(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_arr_i  (req_arr_i),
    .data_arr_i (data_arr_i),
    .gnt_arr_o  (gnt_arr_o),
    .req_o      (req_o),
    .data_o     (data_o),
    .gnt_i      (gnt_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          req;
    logic [DW-1:0] data;
    logic [N-1:0]  gnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   mptr  = 0;   // reference priority pointer

  // Monitor: every cycle the DUT presents an output, check it against the
  // oldest expectation issued by the driver.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (req_o !== e.req || data_o !== e.data || gnt_arr_o !== e.gnt) begin
        bad++;
        $display("FAIL %s: got req=%0b data=%0h gnt=%h, want req=%0b data=%0h gnt=%h",
                 e.tag, req_o, data_o, gnt_arr_o, e.req, e.data, e.gnt);
      end
    end
  end

  // Reference: circular scan from the pointer, first requester wins.
  task automatic drive(input string tag, input logic [N-1:0] r, input logic g,
                       input logic rs, output int w);
    exp_t e;
    logic [N-1:0] one;
    req_arr_i = r;
    gnt_i     = g;
    rst       = rs;
    w         = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (w < 0 && r[idx]) w = idx;
    end
    e.tag  = tag;
    e.req  = 1'b0;
    e.data = '0;
    e.gnt  = '0;
    if (!rs && w >= 0) begin
      e.req  = 1'b1;
      e.data = data_arr_i[w];
      if (g) begin
        one   = 1;
        e.gnt = one << w;
      end
    end
    q.push_back(e);
    @(posedge clk);
    if (rs) mptr = 0;
    else if (w >= 0 && g) mptr = (w + 1) % N;
    #1;
  endtask

  logic [N-1:0] ones;
  logic [N-1:0] r;
  int           w;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ones      = '1;
    rst       = 1'b1;
    gnt_i     = 1'b0;
    req_arr_i = '0;
    for (int i = 0; i < N; i++) data_arr_i[i] = DW'($urandom);
    @(posedge clk);
    #1;

    // Reset holds outputs at zero regardless of inputs
    drive("reset", ones, 1'b1, 1'b1, w);
    drive("reset", ones, 1'b0, 1'b1, w);

    // Full load drain, data word = index
    for (int i = 0; i < N; i++) data_arr_i[i] = DW'(i);
    r = ones;
    for (int k = 0; k < N; k++) begin
      drive("drain", r, 1'b1, 1'b0, w);
      if (w >= 0) r[w] = 1'b0;
    end
    drive("drain_empty", r, 1'b1, 1'b0, w);

    // Back-pressure
    for (int i = 0; i < N; i++) data_arr_i[i] = DW'($urandom);
    repeat (5) drive("backpressure", ones, 1'b0, 1'b0, w);
    drive("bp_release", ones, 1'b1, 1'b0, w);
    drive("bp_next", ones, 1'b1, 1'b0, w);

    // Wrap-around
    r = '0; r[63] = 1'b1;
    drive("wrap_63", r, 1'b1, 1'b0, w);
    r[2] = 1'b1;
    repeat (3) drive("wrap_pair", r, 1'b1, 1'b0, w);

    // Sparse fairness
    r = '0; r[10] = 1'b1;
    drive("sparse_10", r, 1'b1, 1'b0, w);
    r = '0; r[5] = 1'b1; r[40] = 1'b1;
    repeat (6) drive("sparse_pair", r, 1'b1, 1'b0, w);

    // Idle, then confirm pointer unchanged
    repeat (3) drive("idle", '0, 1'b1, 1'b0, w);
    drive("idle_nogrant", '0, 1'b0, 1'b0, w);
    drive("after_idle", ones, 1'b0, 1'b0, w);

    // Reset mid-operation with pointer at 37
    r = '0; r[36] = 1'b1;
    drive("to_37", r, 1'b1, 1'b0, w);
    drive("at_37", ones, 1'b0, 1'b0, w);
    drive("mid_reset", ones, 1'b1, 1'b1, w);
    drive("post_reset", ones, 1'b1, 1'b0, w);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int mode;
      for (int i = 0; i < N; i++) data_arr_i[i] = DW'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0: r = {$urandom, $urandom};
        1: r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2: begin r = '0; r[$urandom_range(0, N-1)] = 1'b1; r[$urandom_range(0, N-1)] = 1'b1; end
        default: r = ($urandom_range(0, 7) == 0) ? '0 : ones;
      endcase
      drive("random", r, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0), w);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
